// File: rtl/calc_stage_pipe.sv
// Elastic DEPTH-stage pipeline carrying NUM_CH data channels plus a tag, with
// valid/ready handshaking, bubble collapsing, synchronous flush and occupancy.
module calc_stage_pipe #(
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int NUM_CH            = 2,
  parameter int DEPTH             = 2,
  parameter int TAG_WIDTH         = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CH*ENGINE_DATA_WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]                in_tag,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_CH*ENGINE_DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]                out_tag,
  output logic [$clog2(DEPTH+1)-1:0]          occupancy
);

  localparam int DW = NUM_CH * ENGINE_DATA_WIDTH;
  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     v;
  logic [DEPTH-1:0]     adv;
  logic [DEPTH-1:0]     load;
  logic [DEPTH-1:0]     v_nxt;
  logic [DW-1:0]        d [DEPTH];
  logic [TAG_WIDTH-1:0] t [DEPTH];
  logic                 in_fire;
  logic [OW-1:0]        occ_nxt;

  // A stage advances when the output drains or any stage above it is empty;
  // this is the unrolled form of the recursive bubble-collapse rule.
  always_comb begin : adv_calc
    logic hole;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hole = 1'b0;
    adv  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hole = 1'b0;
      for (int j = k + 1; j < DEPTH; j++) begin
        hole = hole | ~v[j];
      end
      adv[k] = v[k] & (out_ready | hole);
    end
  end

  assign in_ready = ~flush & (~v[0] | adv[0]);
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    load    = '0;
    v_nxt   = '0;
    occ_nxt = '0;
    load[0] = in_fire;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1];
    end
    // Flush wins over every transfer; the output handshake still completes.
    for (int k = 0; k < DEPTH; k++) begin
      v_nxt[k] = ~flush & (load[k] | (v[k] & ~adv[k]));
    end
    for (int k = 0; k < DEPTH; k++) begin
      occ_nxt = occ_nxt + OW'(v_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v         <= '0;
      occupancy <= '0;
      // NOTE: data/tag registers are reset too because out_data/out_tag must read 0 during reset.
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
        t[k] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      v         <= v_nxt;
      occupancy <= occ_nxt;
      if (load[0]) begin
        d[0] <= in_data;
        t[0] <= in_tag;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          d[k] <= d[k-1];
          t[k] <= t[k-1];
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_tag   = t[DEPTH-1];

endmodule

// File: tb/tb_calc_stage_pipe.sv
// Bench for calc_stage_pipe: two configurations (2ch/2deep/8b tag and
// 4ch/5deep/4b tag) checked against an item-level queue model.
module tb_calc_stage_pipe;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         sel = 1'b0;
  logic [99:0]  in_data = '0;
  logic [7:0]   in_tag = '0;

  logic         a_in_ready, a_out_valid;
  logic [49:0]  a_out_data;
  logic [7:0]   a_out_tag;
  logic [1:0]   a_occ;
  logic         b_in_ready, b_out_valid;
  logic [99:0]  b_out_data;
  logic [3:0]   b_out_tag;
  logic [2:0]   b_occ;

  logic         o_in_ready, o_valid;
  logic [99:0]  o_data;
  logic [7:0]   o_tag;
  logic [2:0]   o_occ;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  calc_stage_pipe #(.ENGINE_DATA_WIDTH(25), .NUM_CH(2), .DEPTH(2), .TAG_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .in_data(in_data[49:0]), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag), .occupancy(a_occ)
  );

  calc_stage_pipe #(.ENGINE_DATA_WIDTH(25), .NUM_CH(4), .DEPTH(5), .TAG_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .in_data(in_data), .in_tag(in_tag[3:0]),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag), .occupancy(b_occ)
  );

  assign o_in_ready = sel ? b_in_ready  : a_in_ready;
  assign o_valid    = sel ? b_out_valid : a_out_valid;
  assign o_data     = sel ? b_out_data  : {50'b0, a_out_data};
  assign o_tag      = sel ? {4'b0, b_out_tag} : a_out_tag;
  assign o_occ      = sel ? b_occ : {1'b0, a_occ};

  // Reference model: in-flight items in arrival order, each with its stage index.
  typedef struct {
    logic [99:0] data;
    logic [7:0]  tag;
    int          pos;
  } item_t;

  item_t       q[$];
  logic        exp_in_ready, exp_out_valid;
  logic [99:0] exp_data;
  logic [7:0]  exp_tag;
  logic [2:0]  exp_occ;

  function automatic int cur_depth();
    return sel ? 5 : 2;
  endfunction

  function automatic logic [99:0] rnd100();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[99:0];
  endfunction

  task automatic model_expect();
    int dep;
    dep           = cur_depth();
    exp_in_ready  = !flush && ((q.size() < dep) || out_ready);
    exp_out_valid = (q.size() > 0) && (q[0].pos == dep - 1);
    exp_data      = exp_out_valid ? q[0].data : '0;
    exp_tag       = exp_out_valid ? q[0].tag : '0;
    exp_occ       = 3'(q.size());
  endtask

  task automatic model_advance();
    int          dep, lim;
    logic        in_fire, out_fire;
    logic [99:0] dmask;
    logic [7:0]  tmask;
    dep      = cur_depth();
    dmask    = sel ? {100{1'b1}} : {50'b0, {50{1'b1}}};
    tmask    = sel ? 8'h0F : 8'hFF;
    in_fire  = in_valid && exp_in_ready;
    out_fire = exp_out_valid && out_ready;
    if (!reset || flush) begin
      q.delete();
      return;
    end
    if (out_fire) void'(q.pop_front());
    lim = dep;
    foreach (q[i]) begin
      if (q[i].pos + 1 < lim) q[i].pos++;
      lim = q[i].pos;
    end
    if (in_fire) q.push_back('{data: in_data & dmask, tag: in_tag & tmask, pos: 0});
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic step();
    model_expect();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = rnd100();
    in_tag    = 8'hC3;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_occ !== 3'd0 || o_data !== '0 || o_tag !== 8'h00) begin
        fails++;
        $display("FAIL reset_outputs: got valid=%b occ=%0d data=%h tag=%h, want all zero",
                 o_valid, o_occ, o_data, o_tag);
      end else passes++;
    end
    q.delete();
    reset    = 1'b1;
    in_valid = 1'b0;
    settle();
    checks++;
    if (o_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", o_in_ready);
    end else passes++;
  endtask

  task automatic test_latency();
    in_data   = {50'b0, 25'h1FFFFFF, 25'h0000123};
    in_tag    = 8'h5A;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    settle();
    checks++;
    if (o_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL latency_accept: in_ready got %b want 1", o_in_ready);
    end else passes++;
    step();
    in_valid = 1'b0;
    settle();
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: out_valid got %b want 0 one cycle after push", o_valid);
    end else passes++;
    step();
    settle();
    checks++;
    if (o_valid !== 1'b1 || o_data[49:0] !== {25'h1FFFFFF, 25'h0000123} || o_tag !== 8'h5A) begin
      fails++;
      $display("FAIL latency_out: got valid=%b data=%h tag=%h want 1 %h 5a",
               o_valid, o_data[49:0], o_tag, {25'h1FFFFFF, 25'h0000123});
    end else passes++;
    step();
    settle();
    checks++;
    if (o_valid !== 1'b0 || o_occ !== 3'd0) begin
      fails++;
      $display("FAIL latency_drain: got valid=%b occ=%0d want 0 0", o_valid, o_occ);
    end else passes++;
  endtask

  task automatic test_streaming();
    int next_tag;
    next_tag  = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (cyc < 16);
      in_tag   = 8'(cyc);
      in_data  = {50'b0, rnd100() & {50{1'b1}}};
      settle();
      checks++;
      if (o_valid !== ((cyc >= 2) && (cyc < 18))) begin
        fails++;
        $display("FAIL stream_valid[%0d]: got %b want %b", cyc, o_valid, (cyc >= 2) && (cyc < 18));
      end else passes++;
      if (cyc >= 2 && cyc < 16) begin
        checks++;
        if (o_occ !== 3'd2) begin
          fails++;
          $display("FAIL stream_occ[%0d]: got %0d want 2", cyc, o_occ);
        end else passes++;
      end
      if (o_valid === 1'b1) begin
        checks++;
        if (o_tag !== 8'(next_tag) || o_data !== exp_data) begin
          fails++;
          $display("FAIL stream_item[%0d]: got tag=%h data=%h want tag=%h data=%h",
                   cyc, o_tag, o_data, 8'(next_tag), exp_data);
        end else passes++;
        next_tag++;
      end
      step();
    end
    checks++;
    if (next_tag != 16) begin
      fails++;
      $display("FAIL stream_count: got %0d outputs want 16", next_tag);
    end else passes++;
  endtask

  task automatic test_backpressure();
    int idx;
    idx       = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = (idx < 3);
      in_tag   = 8'h10 + 8'(idx);
      in_data  = {50'b0, rnd100() & {50{1'b1}}};
      settle();
      if (cyc >= 2) begin
        checks++;
        if (o_in_ready !== 1'b0 || o_occ !== 3'd2 || o_valid !== 1'b1 || o_tag !== 8'h10) begin
          fails++;
          $display("FAIL bp_full[%0d]: got in_ready=%b occ=%0d valid=%b tag=%h want 0 2 1 10",
                   cyc, o_in_ready, o_occ, o_valid, o_tag);
        end else passes++;
      end
      if (in_valid && o_in_ready) idx++;
      step();
    end
    out_ready = 1'b1;
    settle();
    checks++;
    if (o_in_ready !== 1'b1 || o_tag !== 8'h10) begin
      fails++;
      $display("FAIL bp_release: got in_ready=%b tag=%h want 1 10", o_in_ready, o_tag);
    end else passes++;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (k < 2 ? (o_valid !== 1'b1 || o_tag !== 8'h11 + 8'(k)) : (o_valid !== 1'b0)) begin
        fails++;
        $display("FAIL bp_order[%0d]: got valid=%b tag=%h want valid=%b tag=%h",
                 k, o_valid, o_tag, k < 2, 8'h11 + 8'(k));
      end else passes++;
      step();
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = (cyc == 0) || (cyc == 2);
      in_tag   = (cyc == 0) ? 8'hA1 : 8'hB2;
      settle();
      step();
    end
    in_valid = 1'b0;
    settle();
    checks++;
    if (o_occ !== 3'd2 || o_tag !== 8'hA1 || o_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bubble_hold: got occ=%0d tag=%h in_ready=%b want 2 a1 0", o_occ, o_tag, o_in_ready);
    end else passes++;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++;
      if (o_valid !== 1'b1 || o_tag !== (k == 0 ? 8'hA1 : 8'hB2)) begin
        fails++;
        $display("FAIL bubble_out[%0d]: got valid=%b tag=%h want 1 %h",
                 k, o_valid, o_tag, (k == 0 ? 8'hA1 : 8'hB2));
      end else passes++;
      step();
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_tag = 8'h21 + 8'(k);
      settle();
      step();
    end
    in_tag = 8'h33;
    flush  = 1'b1;
    settle();
    checks++;
    if (o_in_ready !== 1'b0 || o_occ !== 3'd2) begin
      fails++;
      $display("FAIL flush_cycle: got in_ready=%b occ=%0d want 0 2", o_in_ready, o_occ);
    end else passes++;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++;
      if (o_valid !== 1'b0 || o_occ !== 3'd0) begin
        fails++;
        $display("FAIL flush_after[%0d]: got valid=%b occ=%0d want 0 0", k, o_valid, o_occ);
      end else passes++;
      step();
    end
  endtask

  task automatic test_async_reset(input logic s);
    int dep;
    sel       = s;
    dep       = cur_depth();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < dep; k++) begin
      in_tag  = 8'h40 + 8'(k);
      in_data = rnd100();
      settle();
      step();
    end
    in_valid = 1'b0;
    settle();
    checks++;
    if (o_occ !== 3'(dep) || o_valid !== 1'b1 || o_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL arst_fill[%0d]: got occ=%0d valid=%b in_ready=%b want %0d 1 0",
               dep, o_occ, o_valid, o_in_ready, dep);
    end else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_occ !== 3'd0) begin
      fails++;
      $display("FAIL arst_immediate[%0d]: got valid=%b occ=%0d want 0 0", dep, o_valid, o_occ);
    end else passes++;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      checks++;
      if (o_valid !== 1'b0 || o_occ !== 3'd0) begin
        fails++;
        $display("FAIL arst_after[%0d/%0d]: got valid=%b occ=%0d want 0 0", dep, k, o_valid, o_occ);
      end else passes++;
      step();
    end
  endtask

  task automatic test_random(input logic s, input int n);
    sel = s;
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_data   = rnd100();
      in_tag    = 8'($urandom());
      settle();
      checks++;
      if (o_in_ready !== exp_in_ready || o_valid !== exp_out_valid || o_occ !== exp_occ) begin
        fails++;
        $display("FAIL rand_ctrl[%0d/%0d]: got in_ready=%b valid=%b occ=%0d want %b %b %0d",
                 s, i, o_in_ready, o_valid, o_occ, exp_in_ready, exp_out_valid, exp_occ);
      end else passes++;
      if (exp_out_valid) begin
        checks++;
        if (o_data !== exp_data || o_tag !== exp_tag) begin
          fails++;
          $display("FAIL rand_item[%0d/%0d]: got data=%h tag=%h want data=%h tag=%h",
                   s, i, o_data, o_tag, exp_data, exp_tag);
        end else passes++;
      end
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random(1'b0, 300);
    test_async_reset(1'b0);
    test_random(1'b1, 400);
    test_async_reset(1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
